// File: rtl/ffd.sv
// Parameterizable D flip-flop / register delay line with asynchronous active-low reset.
// Each stage is WIDTH bits wide; q is the output of the last of STAGES cascaded registers.
`timescale 1ns/1ps
module ffd #(
  parameter int              WIDTH       = 1,
  parameter int              STAGES      = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             aclk,
  input  logic             arstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (WIDTH < 1 || STAGES < 1) begin : g_bad_param
      $fatal(1, "ffd: WIDTH and STAGES must both be at least 1");
    end
  endgenerate

  logic [WIDTH-1:0] r_stage [STAGES];

  // Every stage is reset so in-flight data never survives a reset.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      for (int i = 0; i < STAGES; i++) begin
        r_stage[i] <= RESET_VALUE;
      end
    end else begin
      r_stage[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign q = r_stage[STAGES-1];

endmodule

// File: tb/tb_ffd.sv
// Self-checking bench for ffd: four instances cover the default flop, a 3-stage line,
// a non-zero reset value and a 4-stage line reset mid-stream; queues hold expected q values.
`timescale 1ns/1ps
module tb_ffd;

  logic       clk;
  logic       rstn1, rstn2, rstn3, rstn4;
  logic       d1, q1;
  logic [7:0] d2, q2, d3, q3, d4, q4;

  int total = 0;
  int bad   = 0;

  logic [7:0] sb2[$];
  logic [7:0] sb3[$];
  logic [7:0] sb4[$];
  logic [7:0] exp_v;

  ffd #(.WIDTH(1), .STAGES(1)) u1 (.aclk(clk), .arstn(rstn1), .d(d1), .q(q1));
  ffd #(.WIDTH(8), .STAGES(2), .RESET_VALUE(8'h3C)) u2 (.aclk(clk), .arstn(rstn2), .d(d2), .q(q2));
  ffd #(.WIDTH(8), .STAGES(3)) u3 (.aclk(clk), .arstn(rstn3), .d(d3), .q(q3));
  ffd #(.WIDTH(8), .STAGES(4)) u4 (.aclk(clk), .arstn(rstn4), .d(d4), .q(q4));

  initial clk = 1'b0;
  always #2 clk = ~clk;

  task automatic test_reset();
    int xbad;
    xbad = 0;
    rstn1 = 1'b1; rstn2 = 1'b1; rstn3 = 1'b1; rstn4 = 1'b1;
    d1 = 1'b0; d2 = 8'h00; d3 = 8'h00; d4 = 8'h00;
    #1;
    rstn1 = 1'b0; rstn2 = 1'b0; rstn3 = 1'b0; rstn4 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      #1;
      total++;
      if (q1 !== 1'b0) begin
        bad++;
        if (xbad == 0) $display("FAIL reset_hold_q1 t=%0t got=%b want=0", $time, q1);
        xbad++;
      end
    end
    total++;
    if (q2 !== 8'h3C) begin
      bad++;
      $display("FAIL reset_hold_q2 got=%h want=3c", q2);
    end
    total++;
    if (q3 !== 8'h00) begin
      bad++;
      $display("FAIL reset_hold_q3 got=%h want=00", q3);
    end
    @(negedge clk);
    rstn1 = 1'b1;
    rstn3 = 1'b1;
    #10;
    total++;
    if (q1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_q1 got=%b want=0", q1);
    end
  endtask

  task automatic test_drive();
    @(negedge clk);
    d1 = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    total++;
    if (q1 !== 1'b1) begin
      bad++;
      $display("FAIL drive_one got=%b want=1", q1);
    end
    @(negedge clk);
    d1 = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (q1 !== 1'b0) begin
      bad++;
      $display("FAIL drive_zero got=%b want=0", q1);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    d1 = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (q1 !== 1'b1) begin
      bad++;
      $display("FAIL async_pre got=%b want=1", q1);
    end
    rstn1 = 1'b0;
    #0.1;
    total++;
    if (q1 !== 1'b0) begin
      bad++;
      $display("FAIL async_immediate got=%b want=0", q1);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (q1 !== 1'b0) begin
        bad++;
        $display("FAIL async_hold edge=%0d got=%b want=0", i, q1);
      end
    end
    @(negedge clk);
    rstn1 = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (q1 !== 1'b1) begin
      bad++;
      $display("FAIL async_release_first_edge got=%b want=1", q1);
    end
  endtask

  task automatic test_latency();
    logic [7:0] stim [6];
    stim = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    sb3.delete();
    sb3.push_back(8'h00);
    sb3.push_back(8'h00);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      d3 = stim[i];
      sb3.push_back(stim[i]);
      @(posedge clk);
      #1;
      exp_v = sb3.pop_front();
      total++;
      if (q3 !== exp_v) begin
        bad++;
        $display("FAIL latency cycle=%0d got=%h want=%h", i, q3, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      v = 8'($urandom_range(0, 255));
      d3 = v;
      sb3.push_back(v);
      @(posedge clk);
      #1;
      exp_v = sb3.pop_front();
      total++;
      if (q3 !== exp_v) begin
        bad++;
        $display("FAIL back_to_back cycle=%0d got=%h want=%h", i, q3, exp_v);
      end
    end
  endtask

  task automatic test_reset_value();
    total++;
    if (q2 !== 8'h3C) begin
      bad++;
      $display("FAIL rv_during_reset got=%h want=3c", q2);
    end
    sb2.delete();
    sb2.push_back(8'h3C);
    @(negedge clk);
    rstn2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      d2 = 8'h11 + 8'(i);
      sb2.push_back(d2);
      @(posedge clk);
      #1;
      exp_v = sb2.pop_front();
      total++;
      if (q2 !== exp_v) begin
        bad++;
        $display("FAIL rv_after_release edge=%0d got=%h want=%h", i, q2, exp_v);
      end
    end
  endtask

  task automatic test_mid_reset();
    sb4.delete();
    repeat (3) sb4.push_back(8'h00);
    @(negedge clk);
    rstn4 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) @(negedge clk);
      d4 = 8'(i);
      sb4.push_back(d4);
      @(posedge clk);
      #1;
      exp_v = sb4.pop_front();
      total++;
      if (q4 !== exp_v) begin
        bad++;
        $display("FAIL mid_pre cycle=%0d got=%h want=%h", i, q4, exp_v);
      end
    end
    rstn4 = 1'b0;
    d4 = 8'h99;
    #0.1;
    total++;
    if (q4 !== 8'h00) begin
      bad++;
      $display("FAIL mid_assert got=%h want=00", q4);
    end
    @(posedge clk);
    #1;
    total++;
    if (q4 !== 8'h00) begin
      bad++;
      $display("FAIL mid_hold got=%h want=00", q4);
    end
    rstn4 = 1'b1;
    sb4.delete();
    repeat (3) sb4.push_back(8'h00);
    for (int i = 5; i <= 12; i++) begin
      @(negedge clk);
      d4 = 8'(i);
      sb4.push_back(d4);
      @(posedge clk);
      #1;
      exp_v = sb4.pop_front();
      total++;
      if (q4 !== exp_v) begin
        bad++;
        $display("FAIL mid_post cycle=%0d got=%h want=%h", i, q4, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_drive();
    test_async_reset();
    test_latency();
    test_back_to_back();
    test_reset_value();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
